decode_stage: RTL and testbench

//  Parametrised ID stage for the 5-stage pipeline: holds the architectural register file,

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/decode_regfile.sv | 77 +++++++
 rtl/decode_stage.sv | 144 ++++++++++++++
 tb/tb_decode_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the 5-stage MIPS pipeline stages.
//               Instruction field slice positions, opcode constants and the
//               default data/register-address widths used by IF/ID/EX.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Default widths shared by every pipeline stage
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int RAW_DEF  = 5;

  // Opcodes of interest to the decode stage
  localparam logic [5:0] OP_LW = 6'h23;

  // MIPS instruction field slices
  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  // True when the instruction word is a load (result only known after MEM)
  function automatic logic f_is_load(input logic [31:0] inst);
    return (inst[OP_HI:OP_LO] == OP_LW);
  endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/decode_regfile.sv
`default_nettype none
// ============================================================================
// Module      : decode_regfile
// Description : Architectural register file, NREG x XLEN, one write port and
//               two combinational read ports. r0 reads as zero and ignores
//               writes. A write presented in the same cycle as a read of the
//               same register is forwarded to the read port (write-before-read).
// Ports       : clk, rst_n         clock / async active-low reset
//               i_we/i_waddr/i_wdata   write port (takes effect on clk edge)
//               i_raddr1/o_rdata1      read port 1
//               i_raddr2/o_rdata2      read port 2
// Revision    : 1.0 - initial release
// ============================================================================
module decode_regfile
  import pipe_pkg::*;
#(
  parameter int XLEN          = XLEN_DEF,
  parameter int NREG          = NREG_DEF,
  parameter int RAW           = RAW_DEF,
  parameter int INIT_IDENTITY = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_we,
  input  logic [RAW-1:0]  i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [RAW-1:0]  i_raddr1,
  input  logic [RAW-1:0]  i_raddr2,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2
);

  // r0 has no storage; entries 1..NREG-1 only
  logic [XLEN-1:0] r_regs [NREG-1:1];

  // A write is architecturally visible only for an in-range, non-zero target
  logic w_wr_en;
  assign w_wr_en = i_we && (i_waddr != '0) && (32'(i_waddr) < NREG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) begin
        r_regs[i] <= (INIT_IDENTITY != 0) ? XLEN'(i) : '0;
      end
    end else if (w_wr_en) begin
      // Decoded write keeps every index in range even for odd NREG
      for (int i = 1; i < NREG; i++) begin
        if (i_waddr == RAW'(i)) begin
          r_regs[i] <= i_wdata;
        end
      end
    end
  end

  // Read with same-cycle bypass; r0 and out-of-range addresses return zero
  function automatic logic [XLEN-1:0] f_read(input logic [RAW-1:0] addr);
    logic [XLEN-1:0] v;
    v = '0;
    if (addr != '0) begin
      if (w_wr_en && (i_waddr == addr)) begin
        v = i_wdata;
      end else begin
        for (int i = 1; i < NREG; i++) begin
          if (addr == RAW'(i)) begin
            v = r_regs[i];
          end
        end
      end
    end
    return v;
  endfunction

  assign o_rdata1 = f_read(i_raddr1);
  assign o_rdata2 = f_read(i_raddr2);

endmodule : decode_regfile
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : ID stage of the 5-stage pipeline. Reads both source operands
//               from the register file (with write-back bypass), detects the
//               load-use hazard against the instruction in ID/EX, and drives
//               the ID/EX pipeline register with a valid/ready handshake on
//               both sides. Flush squashes ID/EX and the incoming instruction.
// Ports       : clk, rst_n              clock / async active-low reset
//               in_valid/in_ready       upstream handshake (IF/ID)
//               inst, pc                instruction word and its PC
//               flush                   branch redirect squash
//               wb_we/wb_addr/wb_data   register write-back port
//               out_valid/out_ready     downstream handshake (EX)
//               out_regdata1/2          rs / rt operand values
//               out_rs/out_rt/out_rd    register fields
//               out_pc                  PC passed through
//               out_mem_read            instruction is a load
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
  import pipe_pkg::*;
#(
  parameter int XLEN          = XLEN_DEF,
  parameter int NREG          = NREG_DEF,
  parameter int RAW           = RAW_DEF,
  parameter int INIT_IDENTITY = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [RAW-1:0]  wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_regdata1,
  output logic [XLEN-1:0] out_regdata2,
  output logic [RAW-1:0]  out_rs,
  output logic [RAW-1:0]  out_rt,
  output logic [RAW-1:0]  out_rd,
  output logic [XLEN-1:0] out_pc,
  output logic            out_mem_read
);

  // --------------------------------------------------------------------------
  // Field decode
  // --------------------------------------------------------------------------
  logic [RAW-1:0]  w_rs;
  logic [RAW-1:0]  w_rt;
  logic [RAW-1:0]  w_rd;
  logic            w_is_load;
  logic [XLEN-1:0] w_rdata1;
  logic [XLEN-1:0] w_rdata2;
  logic            w_unused_shamt_funct;

  assign w_rs      = RAW'(inst[RS_HI:RS_LO]);
  assign w_rt      = RAW'(inst[RT_HI:RT_LO]);
  assign w_rd      = RAW'(inst[RD_HI:RD_LO]);
  assign w_is_load = f_is_load(inst);

  // shamt/funct/immediate bits are consumed by EX from its own copy of inst
  assign w_unused_shamt_funct = ^inst[RD_LO-1:0];

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  decode_regfile #(
    .XLEN          (XLEN),
    .NREG          (NREG),
    .RAW           (RAW),
    .INIT_IDENTITY (INIT_IDENTITY)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (wb_we),
    .i_waddr  (wb_addr),
    .i_wdata  (wb_data),
    .i_raddr1 (w_rs),
    .i_raddr2 (w_rt),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );

  // --------------------------------------------------------------------------
  // Handshake / hazard
  // --------------------------------------------------------------------------
  logic w_adv;
  logic w_hz;

  // ID/EX may load when its current content is taken or is empty
  assign w_adv = out_ready | ~out_valid;

  // Load in ID/EX whose destination feeds the incoming instruction: its data
  // is not available until after MEM, so one bubble is inserted. A load to r0
  // produces nothing anyone can depend on.
  assign w_hz = in_valid & out_valid & out_mem_read & (out_rt != '0) &
                ((out_rt == w_rs) | (out_rt == w_rt));

  // Flush always consumes the incoming instruction, even if it would stall
  assign in_ready = flush | (w_adv & ~w_hz);

  // --------------------------------------------------------------------------
  // ID/EX pipeline register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_mem_read <= 1'b0;
      out_regdata1 <= '0;
      out_regdata2 <= '0;
      out_rs       <= '0;
      out_rt       <= '0;
      out_rd       <= '0;
      out_pc       <= '0;
    end else if (flush) begin
      out_valid    <= 1'b0;
      out_mem_read <= 1'b0;
    end else if (w_adv && w_hz) begin
      // Bubble; the dependent instruction stays upstream for one cycle
      out_valid    <= 1'b0;
      out_mem_read <= 1'b0;
    end else if (w_adv) begin
      out_valid    <= in_valid;
      // Empty slots never look like a load to the hazard check
      out_mem_read <= in_valid & w_is_load;
      if (in_valid) begin
        out_regdata1 <= w_rdata1;
        out_regdata2 <= w_rdata2;
        out_rs       <= w_rs;
        out_rt       <= w_rt;
        out_rd       <= w_rd;
        out_pc       <= pc;
      end
    end
    // otherwise downstream backpressure: hold everything
  end

endmodule : decode_stage
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage. Accepted instructions
//               push their expected ID/EX contents (from an independent
//               register-file model) into a queue; instructions taken by
//               execute pop and compare. Directed checks cover handshake,
//               hazard, flush and reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  localparam int XLEN = 32;
  localparam int RAW  = 5;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic            flush;
  logic            wb_we;
  logic [RAW-1:0]  wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_regdata1;
  logic [XLEN-1:0] out_regdata2;
  logic [RAW-1:0]  out_rs;
  logic [RAW-1:0]  out_rt;
  logic [RAW-1:0]  out_rd;
  logic [XLEN-1:0] out_pc;
  logic            out_mem_read;

  decode_stage #(
    .XLEN          (XLEN),
    .NREG          (32),
    .RAW           (RAW),
    .INIT_IDENTITY (1)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .inst         (inst),
    .pc           (pc),
    .flush        (flush),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_regdata1 (out_regdata1),
    .out_regdata2 (out_regdata2),
    .out_rs       (out_rs),
    .out_rt       (out_rt),
    .out_rd       (out_rd),
    .out_pc       (out_pc),
    .out_mem_read (out_mem_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Scoreboard and reference register file
  // --------------------------------------------------------------------------
  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    logic [RAW-1:0]  rs;
    logic [RAW-1:0]  rt;
    logic [RAW-1:0]  rd;
    logic            mr;
  } exp_t;

  exp_t            sb[$];
  logic [XLEN-1:0] model_rf [32];

  function automatic logic [XLEN-1:0] model_read(input logic [RAW-1:0] a);
    if (a == 0) return '0;
    if (wb_we && wb_addr == a) return wb_data;
    return model_rf[a];
  endfunction

  // Inputs change 1 time unit after posedge; everything is stable at negedge
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      for (int i = 0; i < 32; i++) model_rf[i] = XLEN'(i);
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_out", {32'd0, out_pc}, 64'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_pc",   64'(out_pc),       64'(e.pc));
          check("out_rd1",  64'(out_regdata1), 64'(e.d1));
          check("out_rd2",  64'(out_regdata2), 64'(e.d2));
          check("out_rs",   64'(out_rs),       64'(e.rs));
          check("out_rt",   64'(out_rt),       64'(e.rt));
          check("out_rd",   64'(out_rd),       64'(e.rd));
          check("out_mr",   64'(out_mem_read), 64'(e.mr));
        end
      end else if (out_valid && flush) begin
        if (sb.size() != 0) void'(sb.pop_front());
      end
      if (in_valid && in_ready && !flush) begin
        exp_t e;
        e.pc = pc;
        e.rs = inst[25:21];
        e.rt = inst[20:16];
        e.rd = inst[15:11];
        e.d1 = model_read(inst[25:21]);
        e.d2 = model_read(inst[20:16]);
        e.mr = (inst[31:26] == 6'h23);
        sb.push_back(e);
      end
      if (wb_we && wb_addr != 0) model_rf[wb_addr] = wb_data;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] mk_lw(input logic [4:0] rs, input logic [4:0] rt);
    return {6'h23, rs, rt, 16'h0010};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [XLEN-1:0] p);
    in_valid = 1'b1;
    inst     = i;
    pc       = p;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; inst = '0; pc = '0; flush = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    repeat (3) step();
    check("rst_valid", 64'(out_valid),    64'd0);
    check("rst_pc",    64'(out_pc),       64'd0);
    check("rst_rd1",   64'(out_regdata1), 64'd0);
    check("rst_mr",    64'(out_mem_read), 64'd0);
    rst_n = 1'b1;
    step();

    // T1: identity operands, 1-cycle latency
    drive(mk_r(3, 5, 7), 32'h40);
    #1 check("t1_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("t1_valid", 64'(out_valid),    64'd1);
    check("t1_rd1",   64'(out_regdata1), 64'd3);
    check("t1_rd2",   64'(out_regdata2), 64'd5);
    check("t1_rd",    64'(out_rd),       64'd7);
    check("t1_pc",    64'(out_pc),       64'h40);

    // T2: same-cycle bypass, r0 stays zero
    drive(mk_r(3, 0, 2), 32'h80);
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD;
    step();
    wb_addr = 5'd0; wb_data = 32'h1234;
    drive(mk_r(0, 9, 1), 32'h84);
    check("t2_bypass", 64'(out_regdata1), 64'hDEAD);
    step();
    wb_we = 1'b0;
    check("t2_r0_same", 64'(out_regdata1), 64'd0);
    drive(mk_r(0, 3, 1), 32'h88);
    step();
    in_valid = 1'b0;
    check("t2_r0_read", 64'(out_regdata1), 64'd0);
    check("t2_r3_kept", 64'(out_regdata2), 64'hDEAD);

    // T3: load-use bubble, then load to r0 without bubble
    drive(mk_lw(1, 4), 32'h100);
    step();
    drive(mk_r(4, 2, 6), 32'h104);
    #1 check("t3_hz_ready", 64'(in_ready), 64'd0);
    step();
    check("t3_bubble",   64'(out_valid), 64'd0);
    check("t3_ready_ok", 64'(in_ready),  64'd1);
    step();
    in_valid = 1'b0;
    check("t3_issue_v",  64'(out_valid), 64'd1);
    check("t3_issue_pc", 64'(out_pc),    64'h104);
    drive(mk_lw(2, 0), 32'h200);
    step();
    drive(mk_r(0, 0, 3), 32'h204);
    #1 check("t3_rt0_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("t3_rt0_pc", 64'(out_pc), 64'h204);

    // T4: downstream backpressure
    drive(mk_r(6, 7, 8), 32'h300);
    step();
    out_ready = 1'b0;
    drive(mk_r(9, 10, 11), 32'h304);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t4_stall_ready", 64'(in_ready), 64'd0);
      check("t4_stall_pc",    64'(out_pc),   64'h300);
      check("t4_stall_valid", 64'(out_valid), 64'd1);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("t4_resume_pc", 64'(out_pc), 64'h304);
    step();

    // T5: flush during hazard
    drive(mk_lw(1, 4), 32'h400);
    step();
    drive(mk_r(4, 4, 1), 32'h404);
    flush = 1'b1;
    #1 check("t5_flush_ready", 64'(in_ready), 64'd1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("t5_valid", 64'(out_valid),    64'd0);
    check("t5_mr",    64'(out_mem_read), 64'd0);
    step();
    check("t5_dropped", 64'(out_valid), 64'd0);

    // T6: async reset in the middle of a stall
    drive(mk_lw(1, 4), 32'h500);
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hBEEF;
    step();
    wb_we = 1'b0;
    out_ready = 1'b0;
    drive(mk_r(5, 4, 2), 32'h504);
    step();
    step();
    #2 rst_n = 1'b0;
    #1 check("t6_async_valid", 64'(out_valid), 64'd0);
    check("t6_async_pc", 64'(out_pc), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
    drive(mk_r(5, 4, 2), 32'h600);
    step();
    in_valid = 1'b0;
    check("t6_identity_r5", 64'(out_regdata1), 64'd5);
    check("t6_identity_r4", 64'(out_regdata2), 64'd4);

    repeat (3) step();
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_decode_stage
`default_nettype wire
